// File: rtl/id_ex_fwd_if.sv
// ID/EX stage bundle: ID-side decode, downstream hazard info and the latched EX outputs.
interface id_ex_fwd_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_reg_write;
    logic [XLEN-1:0]   memwb_wdata;
    logic              flush;
    logic              hold;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall_id;
    logic [CNT_W-1:0]  lu_stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
               id_reg_write, id_mem_read, exmem_rd, exmem_reg_write,
               memwb_rd, memwb_reg_write, memwb_wdata, flush, hold,
        input  ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_reg_write,
               ex_mem_read, fwd_a_sel, fwd_b_sel, stall_id, lu_stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
               id_reg_write, id_mem_read, exmem_rd, exmem_reg_write,
               memwb_rd, memwb_reg_write, memwb_wdata, flush, hold,
        output ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_reg_write,
               ex_mem_read, fwd_a_sel, fwd_b_sel, stall_id, lu_stall_cnt
    );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// RV32 ID/EX pipeline register with load-use stall detection and registered
// forwarding selects for the EX operand muxes.
module id_ex_fwd_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         reset,
    id_ex_fwd_if.slave  bus
);
    logic            lu_hazard;
    logic            stall;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic            byp_a;
    logic            byp_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    always_comb begin
        lu_hazard = bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
                    (bus.ex_rd != '0) &&
                    ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
        stall = lu_hazard && !bus.hold;
    end

    assign bus.stall_id = stall;

    // Selects describe where the producer will be once this instruction is in EX.
    always_comb begin
        sel_a = 2'b00;
        if (bus.id_rs1 != '0) begin
            if (bus.ex_valid && bus.ex_reg_write && (bus.ex_rd == bus.id_rs1))
                sel_a = 2'b01;
            else if (bus.exmem_reg_write && (bus.exmem_rd == bus.id_rs1))
                sel_a = 2'b10;
        end
    end

    always_comb begin
        sel_b = 2'b00;
        if (bus.id_rs2 != '0) begin
            if (bus.ex_valid && bus.ex_reg_write && (bus.ex_rd == bus.id_rs2))
                sel_b = 2'b01;
            else if (bus.exmem_reg_write && (bus.exmem_rd == bus.id_rs2))
                sel_b = 2'b10;
        end
    end

    // Regfile is read-before-write, so the value retiring this cycle is taken here.
    always_comb begin
        byp_a = bus.memwb_reg_write && (bus.memwb_rd == bus.id_rs1) && (bus.id_rs1 != '0);
        byp_b = bus.memwb_reg_write && (bus.memwb_rd == bus.id_rs2) && (bus.id_rs2 != '0);
        op_a  = byp_a ? bus.memwb_wdata : bus.id_rs1_data;
        op_b  = byp_b ? bus.memwb_wdata : bus.id_rs2_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_rs1_data  <= '0;
            bus.ex_rs2_data  <= '0;
            bus.ex_rd        <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.fwd_a_sel    <= 2'b00;
            bus.fwd_b_sel    <= 2'b00;
            bus.lu_stall_cnt <= '0;
        end else if (bus.flush) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.fwd_a_sel    <= 2'b00;
            bus.fwd_b_sel    <= 2'b00;
        end else if (bus.hold) begin
            bus.ex_valid     <= bus.ex_valid;
        end else if (stall) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.fwd_a_sel    <= 2'b00;
            bus.fwd_b_sel    <= 2'b00;
            if (bus.lu_stall_cnt != {CNT_W{1'b1}})
                bus.lu_stall_cnt <= bus.lu_stall_cnt + CNT_W'(1);
        end else begin
            bus.ex_valid     <= bus.id_valid;
            bus.ex_rs1_data  <= op_a;
            bus.ex_rs2_data  <= op_b;
            bus.ex_rd        <= bus.id_rd;
            bus.ex_reg_write <= bus.id_valid && bus.id_reg_write;
            bus.ex_mem_read  <= bus.id_valid && bus.id_mem_read;
            bus.fwd_a_sel    <= sel_a;
            bus.fwd_b_sel    <= sel_b;
        end
    end
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage; counter narrowed to 8 bits so saturation is reachable quickly.
module tb_id_ex_fwd_stage;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   vec = 0;
    int   errs = 0;
    logic [CNT_W-1:0] exp_cnt;

    id_ex_fwd_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    id_ex_fwd_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_rd = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0;
        bus.exmem_rd = 0; bus.exmem_reg_write = 0;
        bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_wdata = 0;
        bus.flush = 0; bus.hold = 0;
    endtask

    task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic rw, input logic mr);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_reg_write = rw; bus.id_mem_read = mr;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        vec++; if (bus.ex_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", bus.ex_valid); end
        vec++; if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'b0) begin errs++; $display("FAIL reset_sels got %b want 0000", {bus.fwd_a_sel, bus.fwd_b_sel}); end
        vec++; if (bus.lu_stall_cnt !== 8'h00) begin errs++; $display("FAIL reset_cnt got %h want 00", bus.lu_stall_cnt); end
        vec++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_rd} !== 7'b0) begin errs++; $display("FAIL reset_ctl got %b want 0", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_rd}); end
    endtask

    task automatic test_ex_fwd();
        clear_inputs();
        id_instr(5'd1, 5'd2, 5'd5, 1, 0);
        tick();
        vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd5 || bus.ex_reg_write !== 1'b1) begin errs++; $display("FAIL add_latch got v=%b rd=%0d rw=%b want 1/5/1", bus.ex_valid, bus.ex_rd, bus.ex_reg_write); end
        id_instr(5'd5, 5'd6, 5'd8, 1, 0);
        bus.id_rs1_data = 32'h100; bus.id_rs2_data = 32'h200;
        #1;
        vec++; if (bus.stall_id !== 1'b0) begin errs++; $display("FAIL ex_fwd_nostall got %b want 0", bus.stall_id); end
        tick();
        vec++; if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b00) begin errs++; $display("FAIL ex_fwd_sel got %b/%b want 01/00", bus.fwd_a_sel, bus.fwd_b_sel); end
        vec++; if (bus.ex_rs1_data !== 32'h100 || bus.ex_rs2_data !== 32'h200 || bus.ex_rd !== 5'd8) begin errs++; $display("FAIL ex_fwd_data got %h %h %0d want 100 200 8", bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_rd); end
    endtask

    task automatic test_exmem_fwd();
        clear_inputs();
        id_instr(5'd8, 5'd9, 5'd11, 1, 0);
        bus.exmem_rd = 5'd8; bus.exmem_reg_write = 1;
        tick();
        vec++; if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b00) begin errs++; $display("FAIL fwd_priority got %b/%b want 01/00", bus.fwd_a_sel, bus.fwd_b_sel); end
        clear_inputs();
        id_instr(5'd12, 5'd9, 5'd13, 1, 0);
        bus.exmem_rd = 5'd9; bus.exmem_reg_write = 1;
        tick();
        vec++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b10) begin errs++; $display("FAIL exmem_fwd got %b/%b want 00/10", bus.fwd_a_sel, bus.fwd_b_sel); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_instr(5'd2, 5'd0, 5'd7, 1, 1);
        tick();
        vec++; if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd7) begin errs++; $display("FAIL lw_latch got mr=%b rd=%0d want 1/7", bus.ex_mem_read, bus.ex_rd); end
        id_instr(5'd1, 5'd7, 5'd10, 1, 0);
        #1;
        vec++; if (bus.stall_id !== 1'b1) begin errs++; $display("FAIL lu_stall got %b want 1", bus.stall_id); end
        tick();
        exp_cnt = 8'd1;
        vec++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin errs++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b want 000", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read); end
        vec++; if (bus.lu_stall_cnt !== exp_cnt) begin errs++; $display("FAIL lu_cnt got %0d want %0d", bus.lu_stall_cnt, exp_cnt); end
        bus.exmem_rd = 5'd7; bus.exmem_reg_write = 1;
        #1;
        vec++; if (bus.stall_id !== 1'b0) begin errs++; $display("FAIL lu_after_bubble_stall got %b want 0", bus.stall_id); end
        tick();
        vec++; if (bus.fwd_b_sel !== 2'b10 || bus.fwd_a_sel !== 2'b00 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd10) begin errs++; $display("FAIL lu_reload got b=%b a=%b v=%b rd=%0d want 10/00/1/10", bus.fwd_b_sel, bus.fwd_a_sel, bus.ex_valid, bus.ex_rd); end
    endtask

    task automatic test_wb_bypass();
        clear_inputs();
        id_instr(5'd3, 5'd4, 5'd12, 1, 0);
        bus.id_rs1_data = 32'h0; bus.id_rs2_data = 32'h1234;
        bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1; bus.memwb_wdata = 32'hDEADBEEF;
        tick();
        vec++; if (bus.ex_rs1_data !== 32'hDEADBEEF || bus.fwd_a_sel !== 2'b00) begin errs++; $display("FAIL wb_bypass got %h sel=%b want deadbeef/00", bus.ex_rs1_data, bus.fwd_a_sel); end
        vec++; if (bus.ex_rs2_data !== 32'h1234 || bus.fwd_b_sel !== 2'b00) begin errs++; $display("FAIL wb_nobypass got %h sel=%b want 1234/00", bus.ex_rs2_data, bus.fwd_b_sel); end
    endtask

    task automatic test_x0();
        clear_inputs();
        id_instr(5'd5, 5'd6, 5'd0, 1, 1);
        tick();
        clear_inputs();
        id_instr(5'd0, 5'd0, 5'd12, 1, 0);
        bus.id_rs1_data = 32'h11; bus.id_rs2_data = 32'h22;
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1;
        bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1; bus.memwb_wdata = 32'hFFFFFFFF;
        #1;
        vec++; if (bus.stall_id !== 1'b0) begin errs++; $display("FAIL x0_nostall got %b want 0", bus.stall_id); end
        tick();
        vec++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin errs++; $display("FAIL x0_sel got %b/%b want 00/00", bus.fwd_a_sel, bus.fwd_b_sel); end
        vec++; if (bus.ex_rs1_data !== 32'h11 || bus.ex_rs2_data !== 32'h22) begin errs++; $display("FAIL x0_data got %h %h want 11 22", bus.ex_rs1_data, bus.ex_rs2_data); end
    endtask

    task automatic test_flush_hold();
        clear_inputs();
        id_instr(5'd5, 5'd0, 5'd13, 1, 0);
        bus.exmem_rd = 5'd5; bus.exmem_reg_write = 1;
        tick();
        vec++; if (bus.fwd_a_sel !== 2'b10 || bus.ex_rd !== 5'd13) begin errs++; $display("FAIL pre_flush got sel=%b rd=%0d want 10/13", bus.fwd_a_sel, bus.ex_rd); end
        clear_inputs();
        id_instr(5'd1, 5'd2, 5'd14, 1, 1);
        bus.flush = 1; bus.hold = 1;
        tick();
        vec++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.fwd_a_sel !== 2'b00) begin errs++; $display("FAIL flush_hold got v=%b rw=%b mr=%b a=%b want 0/0/0/00", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.fwd_a_sel); end
        vec++; if (bus.ex_rd !== 5'd13 || bus.lu_stall_cnt !== exp_cnt) begin errs++; $display("FAIL flush_keep got rd=%0d cnt=%0d want 13/%0d", bus.ex_rd, bus.lu_stall_cnt, exp_cnt); end
    endtask

    task automatic test_hold();
        clear_inputs();
        id_instr(5'd1, 5'd0, 5'd7, 1, 1);
        bus.id_rs1_data = 32'hAAA;
        tick();
        clear_inputs();
        id_instr(5'd2, 5'd7, 5'd15, 1, 0);
        bus.id_rs1_data = 32'h555;
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++; if (bus.stall_id !== 1'b0) begin errs++; $display("FAIL hold_stall[%0d] got %b want 0", i, bus.stall_id); end
            tick();
            vec++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd7 || bus.ex_mem_read !== 1'b1 || bus.ex_rs1_data !== 32'hAAA || bus.lu_stall_cnt !== exp_cnt) begin
                errs++; $display("FAIL hold_frozen[%0d] got v=%b rd=%0d mr=%b d=%h cnt=%0d want 1/7/1/aaa/%0d", i, bus.ex_valid, bus.ex_rd, bus.ex_mem_read, bus.ex_rs1_data, bus.lu_stall_cnt, exp_cnt);
            end
        end
        bus.hold = 0;
        #1;
        vec++; if (bus.stall_id !== 1'b1) begin errs++; $display("FAIL hold_release_stall got %b want 1", bus.stall_id); end
        tick();
        exp_cnt = exp_cnt + 8'd1;
        vec++; if (bus.ex_valid !== 1'b0 || bus.lu_stall_cnt !== exp_cnt) begin errs++; $display("FAIL hold_release_bubble got v=%b cnt=%0d want 0/%0d", bus.ex_valid, bus.lu_stall_cnt, exp_cnt); end
    endtask

    task automatic test_saturate();
        clear_inputs();
        id_instr(5'd7, 5'd0, 5'd7, 1, 1);
        for (int i = 0; i < 258; i++) begin
            tick();
            tick();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            if (i == 100) begin
                vec++; if (bus.lu_stall_cnt !== exp_cnt) begin errs++; $display("FAIL sat_mid got %0d want %0d", bus.lu_stall_cnt, exp_cnt); end
            end
            if (i == 252) begin
                vec++; if (bus.lu_stall_cnt !== 8'hFF) begin errs++; $display("FAIL sat_reach got %h want ff", bus.lu_stall_cnt); end
            end
        end
        vec++; if (bus.lu_stall_cnt !== 8'hFF || bus.ex_valid !== 1'b0) begin errs++; $display("FAIL sat_hold got cnt=%h v=%b want ff/0", bus.lu_stall_cnt, bus.ex_valid); end
    endtask

    task automatic test_reset_midstream();
        clear_inputs();
        id_instr(5'd7, 5'd0, 5'd9, 1, 1);
        bus.id_rs1_data = 32'h77;
        bus.exmem_rd = 5'd7; bus.exmem_reg_write = 1;
        tick();
        vec++; if (bus.ex_valid !== 1'b1 || bus.fwd_a_sel !== 2'b10) begin errs++; $display("FAIL pre_reset got v=%b a=%b want 1/10", bus.ex_valid, bus.fwd_a_sel); end
        reset = 1;
        tick();
        reset = 0;
        vec++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin errs++; $display("FAIL mid_reset_ctl got v=%b rw=%b mr=%b want 000", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read); end
        vec++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00 || bus.lu_stall_cnt !== 8'h00) begin errs++; $display("FAIL mid_reset_sel_cnt got %b/%b cnt=%h want 00/00/00", bus.fwd_a_sel, bus.fwd_b_sel, bus.lu_stall_cnt); end
        vec++; if (bus.ex_rs1_data !== 32'h0 || bus.ex_rd !== 5'd0) begin errs++; $display("FAIL mid_reset_data got %h rd=%0d want 0/0", bus.ex_rs1_data, bus.ex_rd); end
    endtask

    initial begin
        reset = 1;
        exp_cnt = 8'd0;
        clear_inputs();
        test_reset();
        test_ex_fwd();
        test_exmem_fwd();
        test_load_use();
        test_wb_bypass();
        test_x0();
        test_flush_hold();
        test_hold();
        test_saturate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
